// File: rtl/fifo_burst_packer_pkg.sv
// Shared framing constants and FSM state type for the burst packer.
// Header = {HDR_MAGIC, zeros, seq}; trailer = {TRL_MAGIC, zeros, payload count}.
package fifo_burst_packer_pkg;

    localparam int MAGIC_W = 4;
    localparam int FIELD_W = 8;

    localparam logic [MAGIC_W-1:0] HDR_MAGIC = 4'hA;
    localparam logic [MAGIC_W-1:0] TRL_MAGIC = 4'h5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PAY  = 2'd2,
        S_TRL  = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_burst_packer_buf.sv
// Small synchronous payload FIFO with show-ahead head, occupancy count,
// and legal same-cycle push/pop.
module fifo_burst_packer_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full buffer is only accepted when a pop frees a slot this cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_packer.sv
// Pops words from an async FIFO read port and frames them as header,
// up to BURST_LEN payload words and trailer, closing partial bursts on an idle timeout.
module fifo_burst_packer
    import fifo_burst_packer_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int BURST_LEN      = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int PBUF_DEPTH     = 4
) (
    input  logic                  rd_clk,
    input  logic                  rd_rst_n,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_rd_valid,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic                  ovf_err
);

    localparam int CW = $clog2(PBUF_DEPTH) + 1;
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    state_t               state;
    logic [FIELD_W-1:0]   seq;
    logic [FIELD_W-1:0]   pcount;
    logic [IW-1:0]        idle_cnt;
    logic                 inflight;
    logic                 run;

    logic [DATA_WIDTH-1:0] buf_head;
    logic [CW-1:0]         buf_count;
    logic                  buf_full;
    logic                  buf_empty;
    logic                  buf_pop;
    logic [CW:0]           occupancy;
    logic                  xfer;

    // run holds fifo_rd_en low while in reset and for the first cycle after release.
    assign occupancy  = (CW+1)'(buf_count) + (CW+1)'(inflight);
    assign fifo_rd_en = run && !fifo_empty && (occupancy < (CW+1)'(PBUF_DEPTH));
    assign xfer       = m_valid && m_ready;
    assign buf_pop    = (state == S_PAY) && xfer;

    fifo_burst_packer_buf #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (PBUF_DEPTH)
    ) u_buf (
        .clk       (rd_clk),
        .rst_n     (rd_rst_n),
        .push      (fifo_rd_valid),
        .push_data (fifo_rd_data),
        .pop       (buf_pop),
        .head      (buf_head),
        .count     (buf_count),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    always_comb begin
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_data  = '0;
        case (state)
            S_HDR: begin
                m_valid = 1'b1;
                m_data[DATA_WIDTH-1 -: MAGIC_W] = HDR_MAGIC;
                m_data[FIELD_W-1:0]             = seq;
            end
            S_PAY: begin
                m_valid = !buf_empty;
                m_data  = buf_head;
            end
            S_TRL: begin
                m_valid = 1'b1;
                m_last  = 1'b1;
                m_data[DATA_WIDTH-1 -: MAGIC_W] = TRL_MAGIC;
                m_data[FIELD_W-1:0]             = pcount;
            end
            default: ;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state    <= S_IDLE;
            seq      <= '0;
            pcount   <= '0;
            idle_cnt <= '0;
            inflight <= 1'b0;
            run      <= 1'b0;
            ovf_err  <= 1'b0;
        end else begin
            run      <= 1'b1;
            inflight <= fifo_rd_en;
            if (fifo_rd_valid && (!inflight || (buf_full && !buf_pop))) begin
                ovf_err <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    idle_cnt <= '0;
                    if (!buf_empty) begin
                        state <= S_HDR;
                    end
                end
                S_HDR: begin
                    idle_cnt <= '0;
                    if (xfer) begin
                        pcount <= '0;
                        state  <= S_PAY;
                    end
                end
                S_PAY: begin
                    if (xfer) begin
                        idle_cnt <= '0;
                        pcount   <= pcount + 1'b1;
                        if (({1'b0, pcount} + 9'd1) == 9'(BURST_LEN)) begin
                            state <= S_TRL;
                        end
                    end else if (!buf_empty) begin
                        idle_cnt <= '0;
                    end else if (pcount != '0) begin
                        // Trailer follows the TIMEOUT_CYCLES-th consecutive empty cycle.
                        if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
                            idle_cnt <= '0;
                            state    <= S_TRL;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end
                end
                S_TRL: begin
                    idle_cnt <= '0;
                    if (xfer) begin
                        seq   <= seq + 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_packer.sv
// Bench for fifo_burst_packer: a queue-based FIFO read-port model feeds two instances
// (BURST_LEN 8 and 1); outputs are scored against an expected packet stream.
module tb_fifo_burst_packer;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]         fifo_empty;
    logic [1:0]         fifo_rd_valid;
    logic [1:0]         m_ready;
    logic [1:0][DW-1:0] fifo_rd_data;
    wire  [1:0]         fifo_rd_en;
    wire  [1:0]         m_valid;
    wire  [1:0]         m_last;
    wire  [1:0]         ovf_err;
    wire  [1:0][DW-1:0] m_data;

    fifo_burst_packer #(.DATA_WIDTH(DW), .BURST_LEN(8), .TIMEOUT_CYCLES(TMO), .PBUF_DEPTH(DEPTH)) u_b8 (
        .rd_clk(clk), .rd_rst_n(rst_n), .fifo_rd_data(fifo_rd_data[0]), .fifo_rd_valid(fifo_rd_valid[0]),
        .fifo_empty(fifo_empty[0]), .fifo_rd_en(fifo_rd_en[0]), .m_data(m_data[0]), .m_valid(m_valid[0]),
        .m_ready(m_ready[0]), .m_last(m_last[0]), .ovf_err(ovf_err[0])
    );

    fifo_burst_packer #(.DATA_WIDTH(DW), .BURST_LEN(1), .TIMEOUT_CYCLES(TMO), .PBUF_DEPTH(DEPTH)) u_b1 (
        .rd_clk(clk), .rd_rst_n(rst_n), .fifo_rd_data(fifo_rd_data[1]), .fifo_rd_valid(fifo_rd_valid[1]),
        .fifo_empty(fifo_empty[1]), .fifo_rd_en(fifo_rd_en[1]), .m_data(m_data[1]), .m_valid(m_valid[1]),
        .m_ready(m_ready[1]), .m_last(m_last[1]), .ovf_err(ovf_err[1])
    );

    int n_vec = 0;
    int n_err = 0;
    int rd_count, rd_empty_viol, stab_viol, gap, xfer_count, model_seq, ready_mode;
    bit hold_pending, gap_check;
    logic [DW:0]   held;
    logic [DW-1:0] src_q[$];
    logic [DW:0]   exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected stream: header(seq), up to burst payload words, trailer(count), per packet.
    task automatic queue_words(input int sel, input int n, input int burst, input bit rnd);
        int left;
        int k;
        int chunk;
        logic [DW-1:0] d;
        left = n;
        k = 0;
        while (left > 0) begin
            chunk = (left < burst) ? left : burst;
            exp_q.push_back({1'b0, 16'hA000 | DW'(model_seq)});
            for (int j = 0; j < chunk; j++) begin
                d = rnd ? DW'($urandom) : DW'(k);
                k++;
                src_q.push_back(d);
                exp_q.push_back({1'b0, d});
            end
            exp_q.push_back({1'b1, 16'h5000 | DW'(chunk)});
            model_seq = (model_seq + 1) % 256;
            left -= chunk;
        end
        fifo_empty[sel] = (src_q.size() == 0);
    endtask

    task automatic tick(input int sel);
        logic acc;
        logic [DW:0] got;
        logic [DW:0] e;
        @(negedge clk);
        acc = fifo_rd_en[sel] && !fifo_empty[sel];
        if (fifo_rd_en[sel] && fifo_empty[sel]) rd_empty_viol++;
        got = {m_last[sel], m_data[sel]};
        if (hold_pending && (!m_valid[sel] || got != held)) stab_viol++;
        hold_pending = m_valid[sel] && !m_ready[sel];
        held = got;
        if (!m_valid[sel]) gap++;
        if (m_valid[sel] && m_ready[sel]) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
            check_eq("stream", 32'(got), 32'(e));
            if (gap_check && got[DW]) check_eq("timeout_gap", gap, TMO);
            gap = 0;
            xfer_count++;
        end
        @(posedge clk);
        #1;
        fifo_rd_valid[sel] = acc;
        if (acc) begin
            fifo_rd_data[sel] = src_q.pop_front();
            rd_count++;
        end
        fifo_empty[sel] = (src_q.size() == 0);
        m_ready[sel] = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ready_mode);
    endtask

    task automatic drain(input int sel, input int budget);
        int c;
        c = 0;
        while (exp_q.size() != 0 && c < budget) begin
            tick(sel);
            c++;
        end
        check_eq("drain", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fifo_empty    = 2'b11;
        fifo_rd_valid = 2'b00;
        m_ready       = 2'b00;
        src_q.delete();
        exp_q.delete();
        model_seq = 0;
        hold_pending = 1'b0;
        rd_count = 0;
        rd_empty_viol = 0;
        stab_viol = 0;
        gap = 0;
        xfer_count = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        fifo_empty    = 2'b00;
        fifo_rd_valid = 2'b00;
        m_ready       = 2'b11;
        fifo_rd_data  = '0;
        gap_check     = 1'b0;
        ready_mode    = 1;
        #12;
        check_eq("rst_rd_en", 32'(fifo_rd_en), 0);
        check_eq("rst_m_valid", 32'(m_valid), 0);
        check_eq("rst_m_last", 32'(m_last), 0);
        check_eq("rst_m_data", 32'(m_data[0]), 0);
        check_eq("rst_ovf", 32'(ovf_err), 0);

        // Full burst of 0..7, always ready.
        do_reset();
        ready_mode = 1;
        queue_words(0, 8, 8, 1'b0);
        drain(0, 300);
        check_eq("t1_ovf", 32'(ovf_err[0]), 0);

        // Partial burst closed by timeout.
        do_reset();
        gap_check = 1'b1;
        queue_words(0, 3, 8, 1'b0);
        drain(0, 300);
        gap_check = 1'b0;

        // Random backpressure over four packets.
        do_reset();
        ready_mode = 2;
        queue_words(0, 32, 8, 1'b1);
        drain(0, 2000);
        check_eq("t3_rd_en_empty", rd_empty_viol, 0);
        check_eq("t3_stable", stab_viol, 0);
        check_eq("t3_ovf", 32'(ovf_err[0]), 0);

        // Long stall with a full FIFO: buffer fills, reads stop, header held.
        do_reset();
        ready_mode = 0;
        queue_words(0, 12, 8, 1'b1);
        repeat (100) tick(0);
        check_eq("t4_reads", rd_count, DEPTH);
        check_eq("t4_valid", 32'(m_valid[0]), 1);
        check_eq("t4_hdr_held", 32'(m_data[0]), 32'h0000A000);
        check_eq("t4_rd_en_off", 32'(fifo_rd_en[0]), 0);
        ready_mode = 1;
        drain(0, 500);
        check_eq("t4_stable", stab_viol, 0);
        check_eq("t4_ovf", 32'(ovf_err[0]), 0);

        // Asynchronous reset in the middle of the payload.
        do_reset();
        ready_mode = 1;
        queue_words(0, 8, 8, 1'b1);
        c = 0;
        while (xfer_count < 3 && c < 100) begin
            tick(0);
            c++;
        end
        check_eq("t5_started", xfer_count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_async_valid", 32'(m_valid[0]), 0);
        check_eq("t5_async_rd_en", 32'(fifo_rd_en[0]), 0);
        do_reset();
        queue_words(0, 2, 8, 1'b1);
        drain(0, 300);
        check_eq("t5_ovf", 32'(ovf_err[0]), 0);

        // 257 single-word packets: sequence number wraps.
        do_reset();
        ready_mode = 1;
        queue_words(1, 257, 1, 1'b1);
        drain(1, 4000);
        check_eq("t6_ovf", 32'(ovf_err[1]), 0);
        check_eq("t6_rd_en_empty", rd_empty_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
